// File: rtl/sudoku_loader.sv
// Byte-command front end: synchronises a host strobe, decodes cursor moves and
// cell writes, and issues each write as a valid/ready transaction to the board.
module sudoku_loader #(
    parameter int unsigned N = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       strobe_in,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [3:0] wr_row,
    output logic [3:0] wr_col,
    output logic [3:0] wr_val,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] MaxIdx = 4'(N - 1);
    localparam logic [3:0] MaxVal = 4'(N);

    typedef enum logic {StIdle, StWait} state_e;

    state_e     state_q, state_d;
    logic [1:0] sync_q;
    logic       edge_q;
    logic [3:0] row_q, row_d, col_q, col_d;
    logic [3:0] wr_row_q, wr_row_d, wr_col_q, wr_col_d, wr_val_q, wr_val_d;
    logic       err_q, err_d, done_q, done_d, last_q, last_d;

    logic       cmd_edge, accept, write_ok;
    logic [3:0] nib;

    assign nib      = data_in[3:0];
    assign cmd_edge = sync_q[1] & ~edge_q & ena;
    assign accept   = (state_q == StWait) & wr_ready;
    assign write_ok = (data_in[7:4] == 4'h0) && (nib <= MaxVal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_edge && write_ok) state_d = StWait;
            StWait: if (wr_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_valid = (state_q == StWait);
        busy     = (state_q == StWait);
        wr_row   = wr_row_q;
        wr_col   = wr_col_q;
        wr_val   = wr_val_q;
        done     = done_q;
        err      = err_q;
    end

    // Cursor, pending-write fields and flags.
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        wr_val_d = wr_val_q;
        err_d    = err_q;
        last_d   = 1'b0;
        done_d   = last_q;
        if (accept) begin
            if (col_q == MaxIdx) begin
                col_d = 4'd0;
                if (row_q == MaxIdx) begin
                    row_d  = 4'd0;
                    last_d = 1'b1;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                col_d = col_q + 4'd1;
            end
        end
        if (cmd_edge) begin
            if (state_q == StWait) begin
                // Overrun, including an edge on the acceptance cycle: byte dropped.
                err_d = 1'b1;
            end else if (data_in[7:4] == 4'h0) begin
                if (nib > MaxVal) begin
                    err_d = 1'b1;
                end else begin
                    wr_row_d = row_q;
                    wr_col_d = col_q;
                    wr_val_d = nib;
                end
            end else if (data_in[7:4] == 4'h4) begin
                if (nib > MaxIdx) err_d = 1'b1;
                else row_d = nib;
            end else if (data_in[7:4] == 4'h8) begin
                if (nib > MaxIdx) err_d = 1'b1;
                else col_d = nib;
            end else if (data_in == 8'hC0) begin
                row_d = 4'd0;
                col_d = 4'd0;
                err_d = 1'b0;
            end else if (data_in == 8'hFF) begin
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            edge_q   <= 1'b0;
            row_q    <= 4'd0;
            col_q    <= 4'd0;
            wr_row_q <= 4'd0;
            wr_col_q <= 4'd0;
            wr_val_q <= 4'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], strobe_in};
            edge_q   <= sync_q[1];
            row_q    <= row_d;
            col_q    <= col_d;
            wr_row_q <= wr_row_d;
            wr_col_q <= wr_col_d;
            wr_val_q <= wr_val_d;
            err_q    <= err_d;
            done_q   <= done_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_sudoku_loader.sv
// Self-checking bench for sudoku_loader: vector table, directed corner cases
// and a randomized run against a linear-index reference model.
module tb_sudoku_loader;

    localparam int N = 9;

    logic       clk = 1'b0;
    logic       rst_n, ena, strobe_in, wr_ready;
    logic [7:0] data_in;
    logic       wr_valid, busy, done, err;
    logic [3:0] wr_row, wr_col, wr_val;

    sudoku_loader #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .strobe_in(strobe_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
        .wr_val(wr_val), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] c;
        logic [3:0] v;
    } wr_t;

    typedef struct {
        logic [7:0]  cmd;
        bit          exp_wr;
        logic [11:0] exp_rcv;
        bit          exp_err;
        int          exp_done;
    } vec_t;

    int  n_checks = 0;
    int  n_errs = 0;
    wr_t got_q[$];
    int  done_cnt = 0;
    int  dbl_pulse = 0;
    logic done_prev = 1'b0;
    bit  ready_rand = 1'b0;
    logic ready_fixed = 1'b1;

    // Reference model state: cursor as a linear index.
    int  m_idx, m_err, m_done;

    always @(posedge clk) begin
        #3;
        wr_ready = ready_rand ? logic'($urandom_range(0, 1)) : ready_fixed;
    end

    always @(negedge clk) begin
        if (wr_valid && wr_ready) got_q.push_back({wr_row, wr_col, wr_val});
        if (done) done_cnt++;
        if (done && done_prev) dbl_pulse++;
        done_prev = done;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in   = b;
        strobe_in = 1'b1;
        tick(4);
        strobe_in = 1'b0;
        tick(2);
    endtask

    task automatic expect_write(input string name, input int r, input int c, input int v);
        wr_t w;
        check({name, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check({name, "_rcv"}, int'(w), (r << 8) | (c << 4) | v);
        end
        got_q.delete();
    endtask

    task automatic expect_none(input string name);
        check({name, "_nowrite"}, got_q.size(), 0);
        got_q.delete();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (wr_valid && k < 200) begin
            tick(1);
            k++;
        end
        check("idle_timeout", int'(wr_valid), 0);
    endtask

    function automatic void model(input logic [7:0] b, output bit w, output wr_t e);
        int nb = int'(b[3:0]);
        w = 1'b0;
        e = '0;
        if (b < 8'h10) begin
            if (nb > N) m_err = 1;
            else begin
                w = 1'b1;
                e = {4'(m_idx / N), 4'(m_idx % N), 4'(nb)};
                m_idx++;
                if (m_idx == N * N) begin
                    m_idx = 0;
                    m_done++;
                end
            end
        end else if (b[7:4] == 4'h4) begin
            if (nb > N - 1) m_err = 1;
            else m_idx = nb * N + (m_idx % N);
        end else if (b[7:4] == 4'h8) begin
            if (nb > N - 1) m_err = 1;
            else m_idx = (m_idx / N) * N + nb;
        end else if (b == 8'hC0) begin
            m_idx = 0;
            m_err = 0;
        end else if (b == 8'hFF) begin
            m_done++;
        end else begin
            m_err = 1;
        end
    endfunction

    initial begin
        vec_t vecs[16];
        int   d0;
        bit   ew;
        wr_t  ee;
        logic [7:0] b;

        vecs[0]  = '{8'hC0, 0, 12'h000, 0, 0};
        vecs[1]  = '{8'h43, 0, 12'h000, 0, 0};
        vecs[2]  = '{8'h05, 1, 12'h305, 0, 0};
        vecs[3]  = '{8'h0A, 0, 12'h000, 1, 0};
        vecs[4]  = '{8'hC0, 0, 12'h000, 0, 0};
        vecs[5]  = '{8'h49, 0, 12'h000, 1, 0};
        vecs[6]  = '{8'hC0, 0, 12'h000, 0, 0};
        vecs[7]  = '{8'h8C, 0, 12'h000, 1, 0};
        vecs[8]  = '{8'hC0, 0, 12'h000, 0, 0};
        vecs[9]  = '{8'h23, 0, 12'h000, 1, 0};
        vecs[10] = '{8'hC0, 0, 12'h000, 0, 0};
        vecs[11] = '{8'hFF, 0, 12'h000, 0, 1};
        vecs[12] = '{8'h88, 0, 12'h000, 0, 0};
        vecs[13] = '{8'h48, 0, 12'h000, 0, 0};
        vecs[14] = '{8'h09, 1, 12'h889, 0, 1};
        vecs[15] = '{8'h00, 1, 12'h000, 0, 0};

        rst_n = 1'b0; ena = 1'b1; strobe_in = 1'b0; data_in = 8'h00; wr_ready = 1'b1;
        tick(3);
        check("reset_outputs", int'({wr_valid, busy, done, err, wr_row, wr_col, wr_val}), 0);
        rst_n = 1'b1;
        tick(2);
        check("post_reset_outputs", int'({wr_valid, busy, done, err}), 0);

        // Vector table, ready held high.
        foreach (vecs[i]) begin
            d0 = done_cnt;
            send_byte(vecs[i].cmd);
            if (vecs[i].exp_wr) expect_write($sformatf("vec%0d", i), int'(vecs[i].exp_rcv[11:8]),
                                             int'(vecs[i].exp_rcv[7:4]), int'(vecs[i].exp_rcv[3:0]));
            else expect_none($sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
            check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
        end

        // Sequential fill of the whole board.
        send_byte(8'hC0);
        d0 = done_cnt;
        for (int i = 0; i < N * N; i++) begin
            send_byte(8'(i % 10));
            expect_write($sformatf("fill%0d", i), i / N, i % N, i % 10);
        end
        check("fill_done_pulses", done_cnt - d0, 1);
        send_byte(8'h01);
        expect_write("fill_wrap", 0, 0, 1);

        // Backpressure at (2,8).
        send_byte(8'h42);
        send_byte(8'h88);
        ready_fixed = 1'b0;
        send_byte(8'h07);
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", int'({wr_valid, busy, wr_row, wr_col, wr_val}), 'h3287);
            tick(1);
        end
        ready_fixed = 1'b1;
        tick(3);
        expect_write("bp_accept", 2, 8, 7);
        send_byte(8'h00);
        expect_write("bp_next", 3, 0, 0);

        // Overrun while a write is pending.
        send_byte(8'hC0);
        ready_fixed = 1'b0;
        send_byte(8'h03);
        send_byte(8'h44);
        check("ovr_err", int'(err), 1);
        check("ovr_pending", int'({wr_valid, wr_row, wr_col, wr_val}), 'h1003);
        ready_fixed = 1'b1;
        tick(3);
        expect_write("ovr_single", 0, 0, 3);
        send_byte(8'h02);
        expect_write("ovr_dropped", 0, 1, 2);
        send_byte(8'hC0);
        check("ovr_clear", int'(err), 0);

        // Edge detected on the same cycle the pending write is accepted.
        ready_fixed = 1'b0;
        send_byte(8'h04);
        data_in = 8'h45;
        strobe_in = 1'b1;
        tick(2);
        ready_fixed = 1'b1;
        tick(2);
        strobe_in = 1'b0;
        tick(2);
        expect_write("acc_edge_write", 0, 0, 4);
        check("acc_edge_err", int'(err), 1);
        send_byte(8'h05);
        expect_write("acc_edge_dropped", 0, 1, 5);
        send_byte(8'hC0);

        // Enable gating.
        ena = 1'b0;
        send_byte(8'h01);
        check("ena_low_valid", int'(wr_valid), 0);
        expect_none("ena_low");
        ena = 1'b1;
        send_byte(8'h01);
        expect_write("ena_high", 0, 0, 1);

        // Reset in the middle of a pending write.
        ready_fixed = 1'b0;
        send_byte(8'h06);
        check("rst_mid_pending", int'(wr_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", int'({wr_valid, busy, done, err, wr_row, wr_col, wr_val}), 0);
        tick(1);
        rst_n = 1'b1;
        ready_fixed = 1'b1;
        tick(2);
        expect_none("rst_mid_abandon");
        send_byte(8'h43);
        send_byte(8'h05);
        expect_write("rst_after", 3, 0, 5);

        // Randomized commands against the reference model.
        send_byte(8'hC0);
        got_q.delete();
        m_idx = 0; m_err = 0; m_done = 0;
        d0 = done_cnt;
        ready_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: b = 8'($urandom_range(0, 11));
                5: b = 8'h40 | 8'($urandom_range(0, 10));
                6: b = 8'h80 | 8'($urandom_range(0, 10));
                7: b = ($urandom_range(0, 3) == 0) ? 8'hC0 : 8'hFF;
                default: b = 8'($urandom_range(0, 255));
            endcase
            model(b, ew, ee);
            send_byte(b);
            wait_idle();
            tick(2);
            if (ew) expect_write($sformatf("rnd%0d_b%02h", i, b), int'(ee.r), int'(ee.c), int'(ee.v));
            else expect_none($sformatf("rnd%0d_b%02h", i, b));
            check($sformatf("rnd%0d_err", i), int'(err), m_err);
        end
        ready_rand = 1'b0;
        tick(4);
        check("rnd_done_pulses", done_cnt - d0, m_done);
        check("done_single_cycle", dbl_pulse, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
